// File: rtl/fifo_flag_ctrl.sv
// FIFO pointer and status-flag controller.
// Keeps write/read pointers with a wrap bit, a registered fill level, and the
// full/empty/almost flags and sticky overflow/underflow errors for an external
// 2^ADDR_WIDTH-entry memory.

module fifo_flag_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int AF_THRESH  = 28,
    parameter int AE_THRESH  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_en,
    input  logic                  i_rd_en,
    input  logic                  i_clr,
    input  logic                  i_err_clr,
    output logic [ADDR_WIDTH:0]   o_wr_address,
    output logic [ADDR_WIDTH:0]   o_rd_address,
    output logic                  o_mem_wr_en,
    output logic                  o_mem_rd_en,
    output logic                  o_Full_Flag,
    output logic                  o_Empty_Flag,
    output logic                  o_Almost_Full,
    output logic                  o_Almost_Empty,
    output logic [ADDR_WIDTH:0]   o_level,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int Depth = 1 << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0] AfLevel = (ADDR_WIDTH + 1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AeLevel = (ADDR_WIDTH + 1)'(AE_THRESH);
    localparam logic [ADDR_WIDTH:0] PtrOne  = (ADDR_WIDTH + 1)'(1);

    // Thresholds must be ordered and fit inside the memory depth.
    if (ADDR_WIDTH < 1 || AE_THRESH < 0 || AE_THRESH >= AF_THRESH || AF_THRESH > Depth)
    begin : g_param_check
        $fatal(1, "fifo_flag_ctrl: need ADDR_WIDTH>=1 and 0 <= AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [ADDR_WIDTH:0] r_wr_ptr, w_wr_ptr_d;
    logic [ADDR_WIDTH:0] r_rd_ptr, w_rd_ptr_d;
    logic [ADDR_WIDTH:0] r_level,  w_level_d;
    logic                r_ovf,    w_ovf_d;
    logic                r_unf,    w_unf_d;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;
    logic w_ovf_set;
    logic w_unf_set;

    // Status flags and accept strobes; flags use registered pointers only.
    always_comb begin
        w_full  = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                  (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);
        w_empty = (r_wr_ptr == r_rd_ptr);
        // Reset gates the strobes so no memory access is issued while held in reset.
        w_wr_acc  = i_rst_n & i_wr_en & ~w_full  & ~i_clr;
        w_rd_acc  = i_rst_n & i_rd_en & ~w_empty & ~i_clr;
        w_ovf_set = i_wr_en & w_full  & ~i_clr;
        w_unf_set = i_rd_en & w_empty & ~i_clr;
    end

    // Next-state for pointers, level and sticky errors.
    always_comb begin
        w_wr_ptr_d = r_wr_ptr;
        w_rd_ptr_d = r_rd_ptr;
        w_level_d  = r_level;
        w_ovf_d    = r_ovf;
        w_unf_d    = r_unf;

        if (i_clr) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
            w_level_d  = '0;
        end else begin
            if (w_wr_acc) w_wr_ptr_d = r_wr_ptr + PtrOne;
            if (w_rd_acc) w_rd_ptr_d = r_rd_ptr + PtrOne;
            unique case ({w_wr_acc, w_rd_acc})
                2'b10:   w_level_d = r_level + PtrOne;
                2'b01:   w_level_d = r_level - PtrOne;
                default: w_level_d = r_level;
            endcase
        end

        // A new error in the same cycle as a clear request must survive.
        if (w_ovf_set)      w_ovf_d = 1'b1;
        else if (i_err_clr) w_ovf_d = 1'b0;
        if (w_unf_set)      w_unf_d = 1'b1;
        else if (i_err_clr) w_unf_d = 1'b0;
    end

    // State registers with asynchronous clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_d;
            r_rd_ptr <= w_rd_ptr_d;
            r_level  <= w_level_d;
            r_ovf    <= w_ovf_d;
            r_unf    <= w_unf_d;
        end
    end

    // Output mapping.
    always_comb begin
        o_wr_address   = r_wr_ptr;
        o_rd_address   = r_rd_ptr;
        o_mem_wr_en    = w_wr_acc;
        o_mem_rd_en    = w_rd_acc;
        o_Full_Flag    = w_full;
        o_Empty_Flag   = w_empty;
        o_Almost_Full  = (r_level >= AfLevel);
        o_Almost_Empty = (r_level <= AeLevel);
        o_level        = r_level;
        o_overflow     = r_ovf;
        o_underflow    = r_unf;
    end

endmodule

// File: tb/tb_fifo_flag_ctrl.sv
// Scoreboard bench for fifo_flag_ctrl (ADDR_WIDTH=5, AF=28, AE=4).
// Stimulus applies inputs just after each rising edge and queues the outputs
// expected in that cycle; the monitor pops and compares on the falling edge.

module tb_fifo_flag_ctrl;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_wr_en;
    logic       i_rd_en;
    logic       i_clr;
    logic       i_err_clr;
    logic [5:0] o_wr_address;
    logic [5:0] o_rd_address;
    logic       o_mem_wr_en;
    logic       o_mem_rd_en;
    logic       o_Full_Flag;
    logic       o_Empty_Flag;
    logic       o_Almost_Full;
    logic       o_Almost_Empty;
    logic [5:0] o_level;
    logic       o_overflow;
    logic       o_underflow;

    fifo_flag_ctrl #(
        .ADDR_WIDTH (5),
        .AF_THRESH  (28),
        .AE_THRESH  (4)
    ) u_dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_wr_en        (i_wr_en),
        .i_rd_en        (i_rd_en),
        .i_clr          (i_clr),
        .i_err_clr      (i_err_clr),
        .o_wr_address   (o_wr_address),
        .o_rd_address   (o_rd_address),
        .o_mem_wr_en    (o_mem_wr_en),
        .o_mem_rd_en    (o_mem_rd_en),
        .o_Full_Flag    (o_Full_Flag),
        .o_Empty_Flag   (o_Empty_Flag),
        .o_Almost_Full  (o_Almost_Full),
        .o_Almost_Empty (o_Almost_Empty),
        .o_level        (o_level),
        .o_overflow     (o_overflow),
        .o_underflow    (o_underflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Flag vector order: {mem_wr, mem_rd, full, empty, af, ae, ovf, unf}
    typedef struct {
        string      name;
        logic [5:0] lvl;
        logic [5:0] wa;
        logic [5:0] ra;
        logic [7:0] flg;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic logic [7:0] fl(input bit mwr, input bit mrd, input bit full,
                                      input bit empty, input bit af, input bit ae,
                                      input bit ovf, input bit unf);
        return {mwr, mrd, full, empty, af, ae, ovf, unf};
    endfunction

    task automatic push(input string n, input int lvl, input int wa, input int ra,
                        input logic [7:0] f);
        exp_t e;
        e.name = n;
        e.lvl  = 6'(lvl);
        e.wa   = 6'(wa);
        e.ra   = 6'(ra);
        e.flg  = f;
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit wr, input bit rd, input bit clr, input bit eclr);
        i_wr_en   = wr;
        i_rd_en   = rd;
        i_clr     = clr;
        i_err_clr = eclr;
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    // Monitor: compare every queued expectation against the outputs.
    always @(negedge i_clk) begin
        logic [7:0] got_flg;
        exp_t       e;
        got_flg = {o_mem_wr_en, o_mem_rd_en, o_Full_Flag, o_Empty_Flag,
                   o_Almost_Full, o_Almost_Empty, o_overflow, o_underflow};
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (o_level !== e.lvl || o_wr_address !== e.wa || o_rd_address !== e.ra ||
                got_flg !== e.flg) begin
                n_fail++;
                $display("FAIL %s: got lvl=%0d wa=%0d ra=%0d flg=%b, want lvl=%0d wa=%0d ra=%0d flg=%b",
                         e.name, o_level, o_wr_address, o_rd_address, got_flg,
                         e.lvl, e.wa, e.ra, e.flg);
            end
        end
    end

    initial begin
        i_rst_n = 1'b0;
        drive(0, 0, 0, 0);
        #3;
        push("reset", 0, 0, 0, fl(0, 0, 0, 1, 0, 1, 0, 0));
        repeat (2) tick();
        i_rst_n = 1'b1;

        // Underflow from empty, then flush at level 17.
        drive(0, 1, 0, 0);
        push("rd_empty", 0, 0, 0, fl(0, 0, 0, 1, 0, 1, 0, 0));
        tick();
        drive(0, 0, 0, 0);
        push("unf_set", 0, 0, 0, fl(0, 0, 0, 1, 0, 1, 0, 1));
        tick();
        for (int i = 0; i < 17; i++) begin
            drive(1, 0, 0, 0);
            push("fill17", i, i, 0, fl(1, 0, 0, i == 0, 0, i <= 4, 0, 1));
            tick();
        end
        drive(1, 1, 1, 0);
        push("clr_cycle", 17, 17, 0, fl(0, 0, 0, 0, 0, 0, 0, 1));
        tick();
        drive(0, 0, 0, 0);
        push("after_clr", 0, 0, 0, fl(0, 0, 0, 1, 0, 1, 0, 1));
        tick();
        // Read while empty during flush must not re-set underflow.
        drive(0, 1, 1, 1);
        push("errclr_w_clr", 0, 0, 0, fl(0, 0, 0, 1, 0, 1, 0, 1));
        tick();
        drive(0, 0, 0, 0);
        push("unf_cleared", 0, 0, 0, fl(0, 0, 0, 1, 0, 1, 0, 0));
        tick();

        // 32 writes to full.
        for (int i = 0; i < 32; i++) begin
            drive(1, 0, 0, 0);
            push("fill32", i, i, 0, fl(1, 0, 0, i == 0, i >= 28, i <= 4, 0, 0));
            tick();
        end
        drive(1, 0, 0, 0);
        push("wr_full", 32, 32, 0, fl(0, 0, 1, 0, 1, 0, 0, 0));
        tick();
        drive(0, 0, 0, 0);
        push("ovf_set", 32, 32, 0, fl(0, 0, 1, 0, 1, 0, 1, 0));
        tick();
        for (int i = 0; i < 10; i++) begin
            push("ovf_hold", 32, 32, 0, fl(0, 0, 1, 0, 1, 0, 1, 0));
            tick();
        end
        drive(0, 0, 0, 1);
        push("errclr_cyc", 32, 32, 0, fl(0, 0, 1, 0, 1, 0, 1, 0));
        tick();
        drive(0, 0, 0, 0);
        push("ovf_cleared", 32, 32, 0, fl(0, 0, 1, 0, 1, 0, 0, 0));
        tick();

        // Set and clear in the same cycle: set wins.
        drive(1, 0, 0, 1);
        push("setwin_cyc", 32, 32, 0, fl(0, 0, 1, 0, 1, 0, 0, 0));
        tick();
        drive(0, 0, 0, 1);
        push("set_wins", 32, 32, 0, fl(0, 0, 1, 0, 1, 0, 1, 0));
        tick();
        drive(0, 0, 0, 0);
        push("setwin_cleared", 32, 32, 0, fl(0, 0, 1, 0, 1, 0, 0, 0));
        tick();

        // Full with both requests: only the read goes through.
        drive(1, 1, 0, 0);
        push("full_wr_rd", 32, 32, 0, fl(0, 1, 1, 0, 1, 0, 0, 0));
        tick();
        drive(0, 0, 0, 1);
        push("after_full_wr_rd", 31, 32, 1, fl(0, 0, 0, 0, 1, 0, 1, 0));
        tick();
        drive(0, 0, 1, 0);
        push("clr_at_31", 31, 32, 1, fl(0, 0, 0, 0, 1, 0, 0, 0));
        tick();

        // Empty with both requests: only the write goes through.
        drive(1, 1, 0, 0);
        push("empty_wr_rd", 0, 0, 0, fl(1, 0, 0, 1, 0, 1, 0, 0));
        tick();
        drive(0, 0, 0, 1);
        push("after_empty_wr_rd", 1, 1, 0, fl(0, 0, 0, 0, 0, 1, 0, 1));
        tick();

        // Up to level 10, then 100 cycles of simultaneous traffic.
        for (int i = 1; i < 10; i++) begin
            drive(1, 0, 0, 0);
            push("fill10", i, i, 0, fl(1, 0, 0, 0, 0, i <= 4, 0, 0));
            tick();
        end
        for (int k = 0; k < 100; k++) begin
            drive(1, 1, 0, 0);
            push("steady10", 10, (10 + k) % 64, k % 64, fl(1, 1, 0, 0, 0, 0, 0, 0));
            tick();
        end

        // Up to level 20, then an asynchronous reset pulse between edges.
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 0, 0);
            push("fill20", 10 + i, 46 + i, 36, fl(1, 0, 0, 0, 0, 0, 0, 0));
            tick();
        end
        drive(0, 0, 0, 0);
        push("lvl20", 20, 56, 36, fl(0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        drive(1, 1, 0, 0);
        i_rst_n = 1'b0;
        push("rst_pulse", 0, 0, 0, fl(0, 0, 0, 1, 0, 1, 0, 0));
        @(negedge i_clk);
        #1;
        i_rst_n = 1'b1;
        drive(1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0);
        push("post_rst_write", 1, 1, 0, fl(0, 0, 0, 0, 0, 1, 0, 0));
        tick();

        @(negedge i_clk);
        #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_flag_ctrl.md
FIFO_FLAG_CTRL -- requirements
Module: fifo_flag_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 5, the memory address width (depth DEPTH = 2^ADDR_WIDTH).
REQ-002 The block SHALL have parameter AF_THRESH, default 28, the almost-full level threshold.
REQ-003 The block SHALL have parameter AE_THRESH, default 4, the almost-empty level threshold.
REQ-004 The block SHALL have port i_clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port i_rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port i_wr_en, input, 1 bit, write request.
REQ-007 The block SHALL have port i_rd_en, input, 1 bit, read request.
REQ-008 The block SHALL have port i_clr, input, 1 bit, synchronous flush.
REQ-009 The block SHALL have port i_err_clr, input, 1 bit, synchronous clear of sticky error flags.
REQ-010 The block SHALL have port o_wr_address, output, ADDR_WIDTH+1 bits, write pointer with wrap bit in the MSB.
REQ-011 The block SHALL have port o_rd_address, output, ADDR_WIDTH+1 bits, read pointer with wrap bit in the MSB.
REQ-012 The block SHALL have port o_mem_wr_en, output, 1 bit, accepted write strobe to the memory.
REQ-013 The block SHALL have port o_mem_rd_en, output, 1 bit, accepted read strobe to the memory.
REQ-014 The block SHALL have ports o_Full_Flag, o_Empty_Flag, o_Almost_Full and o_Almost_Empty, all outputs of 1 bit, the status flags.
REQ-015 The block SHALL have port o_level, output, ADDR_WIDTH+1 bits, current fill count (0..DEPTH).
REQ-016 The block SHALL have ports o_overflow and o_underflow, outputs of 1 bit, sticky error flags.

Function
REQ-017 A write SHALL be accepted (o_mem_wr_en=1) when i_wr_en=1, o_Full_Flag=0 and i_clr=0; this is combinational from the current-cycle inputs and flags.
REQ-018 A read SHALL be accepted (o_mem_rd_en=1) when i_rd_en=1, o_Empty_Flag=0 and i_clr=0.
REQ-019 On each accepted write or read, the corresponding pointer SHALL increment by 1 modulo 2^(ADDR_WIDTH+1) at the clock edge; all-ones SHALL wrap to 0 and toggle the wrap bit.
REQ-020 o_level SHALL be registered: +1 on a write-only accept, -1 on a read-only accept, unchanged when both or neither are accepted; o_level SHALL always equal (wr - rd) mod 2^(ADDR_WIDTH+1).
REQ-021 o_Full_Flag SHALL be 1 iff the pointer MSBs differ and the lower ADDR_WIDTH bits are equal (o_level = DEPTH).
REQ-022 o_Empty_Flag SHALL be 1 iff the pointers are fully equal (o_level = 0).
REQ-023 o_Almost_Full SHALL be 1 iff o_level >= AF_THRESH; o_Almost_Empty SHALL be 1 iff o_level <= AE_THRESH.
REQ-024 All flags SHALL derive only from registered state and SHALL reflect an accepted operation in the cycle after its edge (1-cycle latency), with no glitch dependence on the request inputs.
REQ-025 When full and both requests are high, the read SHALL be accepted and the write rejected, giving level DEPTH-1.
REQ-026 When empty and both requests are high, the write SHALL be accepted and the read rejected, giving level 1.
REQ-027 When neither full nor empty and both requests are high, both SHALL be accepted, with level unchanged and both pointers advancing.
REQ-028 i_wr_en=1 while o_Full_Flag=1 (write rejected) SHALL set o_overflow at the next edge; i_rd_en=1 while o_Empty_Flag=1 SHALL set o_underflow at the next edge.
REQ-029 The sticky flags SHALL hold until i_err_clr=1 or reset; when set and clear coincide in a cycle, set SHALL win.
REQ-030 i_clr=1 SHALL zero both pointers and o_level at the next edge, override i_wr_en and i_rd_en, and leave o_overflow/o_underflow unchanged; requests during i_clr SHALL NOT set error flags.
REQ-031 Parameters SHALL satisfy 0 <= AE_THRESH < AF_THRESH <= DEPTH; a violation SHALL stop elaboration.

Reset
REQ-032 With i_rst_n=0, the block SHALL immediately (asynchronously) clear pointers, o_level, o_overflow and o_underflow, giving o_Empty_Flag=1, o_Almost_Empty=1, o_Full_Flag=0, o_Almost_Full=0, o_mem_wr_en=0 and o_mem_rd_en=0.
REQ-033 Reset asserted mid-operation SHALL discard all contents, and the first edge after release SHALL behave as an empty FIFO.

Verification (ADDR_WIDTH=5, AF_THRESH=28, AE_THRESH=4)
REQ-034 The bench SHALL cover: 32 consecutive writes from reset -> o_level=32, o_Full_Flag=1, o_wr_address=6'b100000, o_Almost_Full set after the 28th write, o_Almost_Empty clear after the 5th write.
REQ-035 The bench SHALL cover: a 33rd write while full -> o_mem_wr_en=0, pointers unchanged, o_overflow=1 next cycle and still 1 after 10 idle cycles; then i_err_clr -> 0.
REQ-036 The bench SHALL cover: full with simultaneous write and read -> only the read accepted, o_level=31, o_Full_Flag=0; empty with simultaneous write and read -> only the write accepted, o_level=1.
REQ-037 The bench SHALL cover: 100 cycles of simultaneous write and read at level 10 -> o_level stays 10, pointers wrap past 63 to 0, and no flag toggles.
REQ-038 The bench SHALL cover: read from empty after reset -> o_underflow=1; then i_clr at level 17 -> o_level=0, o_Empty_Flag=1, o_underflow still 1.
REQ-039 The bench SHALL cover: i_rst_n pulsed low between edges at level 20 -> outputs at their reset values before the next edge.
